// File: rtl/adc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_pkg : window constants and FSM state encoding for the sigma-delta ADC
// Revision: 1.0
// ----------------------------------------------------------------------------
package adc_pkg;

  localparam int WINDOW  = 255;
  localparam int PHASE_W = 8;
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_sync2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync2 : two-flop synchronizer for the asynchronous comparator input
// Revision: 1.0
// ----------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule
`default_nettype wire

// File: rtl/adc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc : first-order sigma-delta ADC, 255-cycle counting window, 8-bit result
// Revision: 1.0
// ----------------------------------------------------------------------------
module adc
  import adc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       cmp,
  output logic       fb,
  output logic [7:0] dout,
  output logic       valid
);

  logic               b;
  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [7:0]         acc_q, acc_d;
  logic [7:0]         dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               fb_q, fb_d;
  logic [7:0]         sum;
  logic               last;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (cmp),
    .q   (b)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    // acc never exceeds 254 at the last phase, so sum cannot wrap
    sum     = acc_q + 8'(b);
    last    = (phase_q == LAST_PHASE);

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SETTLE;
          phase_d = '0;
          acc_d   = '0;
        end
      end
      SETTLE, RUN: begin
        if (!en) begin
          state_d = IDLE;
          phase_d = '0;
          acc_d   = '0;
        end else if (last) begin
          phase_d = '0;
          acc_d   = '0;
          if (state_q == RUN) begin
            dout_d  = sum;
            valid_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          phase_d = phase_q + PHASE_W'(1);
          acc_d   = sum;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
        acc_d   = '0;
      end
    endcase

    // Gated on the next state so the registered fb is already 0 in IDLE
    fb_d = (state_d == IDLE) ? 1'b0 : b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      fb_q    <= fb_d;
    end
  end

  assign fb    = fb_q;
  assign dout  = dout_q;
  assign valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_adc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_adc : scoreboard bench for adc (directed cmp patterns, en drops, resets)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_adc;

  localparam int M_ZERO = 0;
  localparam int M_ONE  = 1;
  localparam int M_TOG  = 2;
  localparam int M_RC   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       cmp = 1'b0;
  logic       fb;
  logic [7:0] dout;
  logic       valid;

  adc dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .cmp   (cmp),
    .fb    (fb),
    .dout  (dout),
    .valid (valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] dout;
    int         tol;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Comparator source. The RC mode integrates vin - fb and looks ahead over
  // the bits still in flight in the sync/fb pipeline, so the closed loop acts
  // like an ideal first-order modulator.
  int mode  = M_ZERO;
  int vin4  = 0;
  int integ = 0;
  int h1    = 0;
  int h2    = 0;

  always @(negedge clk) begin : p_cmp
    int j;
    case (mode)
      M_ZERO: cmp = 1'b0;
      M_ONE:  cmp = 1'b1;
      M_TOG:  cmp = cyc[0];
      default: begin
        integ = integ + vin4 - 4 * int'(fb);
        j     = integ + 2 * vin4 - 4 * (h1 + h2);
        h2    = h1;
        h1    = (j > 0) ? 1 : 0;
        cmp   = (j > 0);
      end
    endcase
  end

  always @(negedge clk) begin : p_monitor
    exp_t e;
    int   d;
    if (valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: valid=1 at cycle %0d dout=%02h, required valid=0", cyc, dout);
      end else begin
        e = sb.pop_front();
        d = int'(dout) - int'(e.dout);
        if (d < 0) d = -d;
        if (d > e.tol || cyc != e.cyc)
          begin
            errors++;
            $display("FAIL window_result: got dout=%02h at cycle %0d, required %02h (+/-%0d) at cycle %0d",
                     dout, cyc, e.dout, e.tol, e.cyc);
          end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] d, input int tol, input int c);
    exp_t e;
    e.dout = d;
    e.tol  = tol;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL valid_timeout: %0d results still pending after %0d cycles, required 0", sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic start(output int k);
    @(negedge clk);
    en = 1'b1;
    k  = cyc;
  endtask

  task automatic stop();
    @(negedge clk);
    en = 1'b0;
  endtask

  initial begin : p_stim
    int k;
    int r;
    int first;
    logic [7:0] rc_exp;

    #12;
    check("reset_dout", int'(dout), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_fb", int'(fb), 0);
    @(negedge clk);
    rst = 1'b0;

    // cmp high: full scale, first result 510 edges after en is sampled
    mode = M_ONE;
    repeat (3) @(negedge clk);
    start(k);
    for (int i = 0; i < 3; i++) push(8'hFF, 0, k + 511 + 255 * i);
    wait_empty(1200);
    stop();
    repeat (3) @(negedge clk);
    check("idle_fb", int'(fb), 0);
    check("idle_dout_hold", int'(dout), 255);

    // cmp low: zero scale
    mode = M_ZERO;
    repeat (3) @(negedge clk);
    start(k);
    for (int i = 0; i < 2; i++) push(8'h00, 0, k + 511 + 255 * i);
    wait_empty(900);
    stop();

    // cmp toggling: odd window length alternates 0x7F / 0x80
    mode = M_TOG;
    repeat (3) @(negedge clk);
    start(k);
    first = ((k + 257) % 2 == 0) ? 128 : 127;
    for (int i = 0; i < 4; i++)
      push((i % 2 == 0) ? 8'(first) : 8'(255 - first), 0, k + 511 + 255 * i);
    wait_empty(1600);
    stop();

    // en dropped at phase 100 of a RUN window, then re-raised
    mode = M_ONE;
    repeat (3) @(negedge clk);
    start(k);
    push(8'hFF, 0, k + 511);
    wait_empty(600);
    wait_cyc(k + 611);
    en = 1'b0;
    repeat (300) @(negedge clk);
    check("drop_dout_hold", int'(dout), 255);
    check("drop_fb", int'(fb), 0);
    start(k);
    push(8'hFF, 0, k + 511);
    wait_empty(600);

    // en dropped exactly on the phase-254 edge: the drop wins
    mode = M_ZERO;
    wait_cyc(k + 765);
    en = 1'b0;
    repeat (20) @(negedge clk);
    check("edge_drop_dout", int'(dout), 255);

    // rst mid-RUN
    mode = M_ONE;
    repeat (3) @(negedge clk);
    start(k);
    push(8'hFF, 0, k + 511);
    wait_empty(600);
    wait_cyc(k + 600);
    rst = 1'b1;
    #1;
    check("rst_mid_dout", int'(dout), 0);
    check("rst_mid_valid", int'(valid), 0);
    check("rst_mid_fb", int'(fb), 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    r   = cyc;
    push(8'hFF, 0, r + 511);
    wait_empty(600);

    // rst held across a phase-254 edge
    wait_cyc(r + 765);
    rst = 1'b1;
    #1;
    check("rst_edge_dout", int'(dout), 0);
    check("rst_edge_valid", int'(valid), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r   = cyc;
    push(8'hFF, 0, r + 511);
    wait_empty(600);
    stop();

    // closed loop at 0.25, 0.5 and 0.75 of full scale
    for (int v = 1; v <= 3; v++) begin
      stop();
      repeat (5) @(negedge clk);
      mode  = M_RC;
      vin4  = v;
      integ = 0;
      h1    = 0;
      h2    = 0;
      start(k);
      rc_exp = (v == 1) ? 8'h40 : ((v == 2) ? 8'h80 : 8'hBF);
      for (int i = 0; i < 3; i++) push(rc_exp, 2, k + 511 + 255 * i);
      wait_empty(1200);
    end
    stop();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/adc.md
ADC -- requirements
Module: adc

Interface
REQ-001 The interface SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port `clk` SHALL be a 1-bit input: the single clock; all state updates on its rising edge.
REQ-003 Port `rst` SHALL be a 1-bit input: asynchronous, active-high reset.
REQ-004 Port `en` SHALL be a 1-bit input: conversion enable, synchronous to `clk`.
REQ-005 Port `cmp` SHALL be a 1-bit input: external comparator result, asynchronous to `clk`.
REQ-006 Port `fb` SHALL be a 1-bit output: first-order sigma-delta feedback bit driven to the external RC network.
REQ-007 Port `dout` SHALL be an 8-bit output: last completed conversion result, unsigned, 0x00 means 0 V and 0xFF means full scale.
REQ-008 Port `valid` SHALL be a 1-bit output: one-cycle strobe marking a new `dout`.

Function
REQ-009 `cmp` SHALL pass through a 2-flop synchronizer; the second-stage output is the modulator bit b.
REQ-010 `fb` SHALL equal b, registered, and SHALL be 0 whenever the state is IDLE.
REQ-011 The FSM SHALL have exactly three states: IDLE, SETTLE and RUN.
REQ-012 In IDLE, sampling en=1 SHALL move the FSM to SETTLE, with phase=0 and acc=0.
REQ-013 In SETTLE or RUN, sampling en=0 SHALL move the FSM to IDLE on that edge: the partial window is discarded, acc and phase clear, and `dout` holds.
REQ-014 In SETTLE or RUN, each edge SHALL advance phase from 0 to 254 and then wrap to 0, giving a window of exactly 255 cycles.
REQ-015 In SETTLE or RUN, each edge SHALL add b to acc, where acc is 8 bits.
REQ-016 At the edge where phase=254, sum = acc + b SHALL be 0..255, with no overflow possible and no saturation logic.
REQ-017 In SETTLE at phase=254, the result SHALL be discarded, acc SHALL clear and the FSM SHALL move to RUN.
REQ-018 In RUN at phase=254, dout SHALL take sum, acc SHALL clear and valid SHALL be 1 for exactly the next cycle.
REQ-019 `valid` SHALL be 0 in every other cycle, including IDLE, SETTLE and the cycle of an en drop.
REQ-020 Latency: with en held high, the first valid SHALL assert in the cycle after the 510th edge following the edge that samples en=1, and each subsequent valid SHALL follow exactly 255 cycles later.
REQ-021 Latency from `cmp` to b SHALL be 2 cycles, and to `fb` 3 cycles.
REQ-022 If en=0 is sampled on a phase=254 edge, the en drop SHALL win: no valid and no dout update.

Reset
REQ-023 Asserting `rst` SHALL immediately force: state IDLE; phase, acc, both synchronizer flops, `fb`, `dout` and `valid` all 0.
REQ-024 Reset asserted mid-window SHALL discard all conversion progress.
REQ-025 After reset deasserts, conversion SHALL restart through SETTLE.

Structure
REQ-026 A shared package adc_pkg SHALL hold the WINDOW constant (255), the PHASE_W constant (8) and the state enum {IDLE, SETTLE, RUN}.
REQ-027 The design SHALL contain exactly one sub-module, sync2: a 2-flop synchronizer with clk and rst ports and a 1-bit d/q path that resets to 0.
REQ-028 The window counter, accumulator and FSM SHALL reside in adc itself.

Verification
REQ-029 Reset, then en=1 with cmp=1 constant -> the first valid SHALL appear exactly 510 edges after en is sampled, and every dout SHALL be 0xFF.
REQ-030 cmp=0 constant -> every dout SHALL be 0x00, with valid at a 255-cycle period.
REQ-031 cmp toggling every clk -> dout SHALL alternate between 0x7F and 0x80 in consecutive windows.
REQ-032 Closed-loop RC/comparator model driven by `fb` with vin at 0.25, 0.5 and 0.75 of full scale -> dout SHALL settle within ±2 LSB of 0x40, 0x80 and 0xBF respectively.
REQ-033 en dropped at phase 100 of a RUN window, then re-raised -> no valid SHALL occur during the drop, dout SHALL hold its previous value, and the next valid SHALL come 510 edges after the re-raise.
REQ-034 rst pulsed mid-RUN (and also coinciding with phase=254) -> all outputs SHALL be 0 immediately, and no valid SHALL occur until SETTLE completes again.
